// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
// The picker and the arbiter top both import this package.
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Upper bound on requester count supported by the rotated-mask helper.
    localparam int MAX_REQ = 32;

    // Bits needed for a counter that must hold values 0..max_val without wrapping.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // One-hot mask selecting requester (ptr + k) mod n.
    function automatic logic [MAX_REQ-1:0] rot_onehot(input int n, input int ptr, input int k);
        logic [MAX_REQ-1:0] m;
        m = MAX_REQ'(1'b1) << ((ptr + k) % n);
        return m;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first active request after i_ptr, wrapping.
// The search starts at i_ptr+1, so the previous owner has the lowest priority.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_pick,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [MAX_REQ-1:0] w_req_ext;
    logic [MAX_REQ-1:0] w_rot;
    logic               w_found;

    assign w_req_ext = MAX_REQ'(i_req);

    // Walk the priority order once; the first hit wins.
    always_comb begin
        o_pick  = '0;
        o_idx   = '0;
        o_any   = |i_req;
        w_found = 1'b0;
        w_rot   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_rot = rot_onehot(NUM_REQ, int'(i_ptr), k);
            if (!w_found && ((w_req_ext & w_rot) != '0)) begin
                w_found = 1'b1;
                o_pick  = w_rot[NUM_REQ-1:0];
                o_idx   = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Burst-granular round-robin arbiter sharing one valid/ready channel.
// Grant held until last beat; watchdog and beat limit force early release.
module rr_burst_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    output logic [$clog2(NUM_REQ)-1:0]  out_id,
    input  logic                        out_ready,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        busy,
    output logic                        err_timeout,
    output logic                        err_burst
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = cnt_width(MAX_BURST);
    localparam int IDLE_W = cnt_width(TIMEOUT);

    arb_state_e          r_state;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [IDX_W-1:0]    r_id;
    logic                r_busy;
    logic [IDX_W-1:0]    r_ptr;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [IDLE_W-1:0]   r_idle_cnt;
    logic                r_err_timeout;
    logic                r_err_burst;

    arb_state_e          w_state_nxt;
    logic [NUM_REQ-1:0]  w_gnt_nxt;
    logic [IDX_W-1:0]    w_id_nxt;
    logic                w_busy_nxt;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic [BEAT_W-1:0]   w_beat_nxt;
    logic [IDLE_W-1:0]   w_idle_nxt;
    logic                w_err_timeout_nxt;
    logic                w_err_burst_nxt;

    logic [NUM_REQ-1:0]  w_pick;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_any;

    logic                w_busy_st;
    logic                w_own_valid;
    logic                w_own_last;
    logic [DATA_W-1:0]   w_own_data;
    logic                w_cap;
    logic                w_accept;
    logic                w_idle_tick;
    logic                w_timeout;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_busy_st   = (r_state == BUSY);
    assign w_own_valid = req_valid[r_id];
    assign w_own_last  = req_last[r_id];
    assign w_own_data  = req_data[int'(r_id)*DATA_W +: DATA_W];
    assign w_cap       = (r_beat_cnt == BEAT_W'(MAX_BURST - 1));

    // The beat path is combinational so a granted owner sees zero-latency ready.
    assign out_valid   = w_busy_st & w_own_valid;
    assign out_data    = w_busy_st ? w_own_data : {DATA_W{1'b0}};
    assign out_last    = w_busy_st & (w_own_last | w_cap);
    assign req_ready   = r_gnt & {NUM_REQ{out_ready}};

    assign w_accept    = out_valid & out_ready;
    assign w_idle_tick = w_busy_st & ~w_own_valid;
    assign w_timeout   = w_idle_tick & (r_idle_cnt == IDLE_W'(TIMEOUT - 1));

    // Next-state and next-register computation for the IDLE/BUSY FSM.
    always_comb begin
        w_state_nxt       = r_state;
        w_gnt_nxt         = r_gnt;
        w_id_nxt          = r_id;
        w_busy_nxt        = r_busy;
        w_ptr_nxt         = r_ptr;
        w_beat_nxt        = r_beat_cnt;
        w_idle_nxt        = r_idle_cnt;
        w_err_timeout_nxt = 1'b0;
        w_err_burst_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = BUSY;
                    w_gnt_nxt   = w_pick;
                    w_id_nxt    = w_pick_idx;
                    w_busy_nxt  = 1'b1;
                    w_beat_nxt  = '0;
                    w_idle_nxt  = '0;
                end else begin
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end
            end
            BUSY: begin
                if (w_accept && out_last) begin
                    // Release; a missing req_last means the beat limit cut the burst.
                    w_state_nxt     = IDLE;
                    w_gnt_nxt       = '0;
                    w_busy_nxt      = 1'b0;
                    w_ptr_nxt       = r_id;
                    w_beat_nxt      = '0;
                    w_idle_nxt      = '0;
                    w_err_burst_nxt = ~w_own_last;
                end else if (w_accept) begin
                    w_beat_nxt = r_beat_cnt + BEAT_W'(1'b1);
                    w_idle_nxt = '0;
                end else if (w_timeout) begin
                    w_state_nxt       = IDLE;
                    w_gnt_nxt         = '0;
                    w_busy_nxt        = 1'b0;
                    w_ptr_nxt         = r_id;
                    w_beat_nxt        = '0;
                    w_idle_nxt        = '0;
                    w_err_timeout_nxt = 1'b1;
                end else if (w_idle_tick) begin
                    w_idle_nxt = r_idle_cnt + IDLE_W'(1'b1);
                end else begin
                    // Valid but back-pressured: watchdog count is frozen.
                    w_idle_nxt = r_idle_cnt;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
                w_beat_nxt  = '0;
                w_idle_nxt  = '0;
            end
        endcase
    end

    // State and arbitration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_gnt         <= '0;
            r_id          <= '0;
            r_busy        <= 1'b0;
            r_ptr         <= IDX_W'(NUM_REQ - 1);
            r_beat_cnt    <= '0;
            r_idle_cnt    <= '0;
            r_err_timeout <= 1'b0;
            r_err_burst   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_gnt         <= w_gnt_nxt;
            r_id          <= w_id_nxt;
            r_busy        <= w_busy_nxt;
            r_ptr         <= w_ptr_nxt;
            r_beat_cnt    <= w_beat_nxt;
            r_idle_cnt    <= w_idle_nxt;
            r_err_timeout <= w_err_timeout_nxt;
            r_err_burst   <= w_err_burst_nxt;
        end
    end

    assign gnt         = r_gnt;
    assign busy        = r_busy;
    assign out_id      = r_id;
    assign err_timeout = r_err_timeout;
    assign err_burst   = r_err_burst;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Scoreboard bench for rr_burst_arbiter: requester models feed bursts, expected
// beats are queued per scenario and popped as the downstream accepts them.
module tb_rr_burst_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 16;
    localparam int TIMEOUT   = 64;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_last;
    logic [1:0]                out_id;
    logic                      out_ready;
    logic [NUM_REQ-1:0]        gnt;
    logic                      busy;
    logic                      err_timeout;
    logic                      err_burst;

    always #5 clk = ~clk;

    rr_burst_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_id      (out_id),
        .out_ready   (out_ready),
        .gnt         (gnt),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_burst   (err_burst)
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       sb[$];
    logic [31:0] m_data [NUM_REQ][64];
    logic        m_last [NUM_REQ][64];
    int          m_len  [NUM_REQ];
    int          m_pos  [NUM_REQ];
    bit          m_pause[NUM_REQ];

    int          n_tests = 0;
    int          n_fail  = 0;

    logic [3:0]  s_gnt, prev_gnt;
    logic        s_busy, s_err_timeout, s_err_burst, s_out_valid;
    logic [31:0] s_out_data;
    logic [3:0]  gnt_log[$];
    int          gap_log[$];
    int          gap;

    function automatic logic [31:0] dat(input int r, input int k);
        return (32'(r) << 24) | 32'h00A5_0000 | 32'(k);
    endfunction

    task automatic load(input int r, input int n, input int bl);
        for (int k = 0; k < n; k++) begin
            m_data[r][k] = dat(r, k);
            m_last[r][k] = (bl > 0) && (((k + 1) % bl) == 0);
        end
        m_len[r] = n;
        m_pos[r] = 0;
    endtask

    task automatic exp_beat(input int r, input int k, input bit last);
        beat_t e;
        e.id   = 2'(r);
        e.data = dat(r, k);
        e.last = last;
        sb.push_back(e);
    endtask

    function automatic bit drained();
        bit d;
        d = (sb.size() == 0);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (m_pos[i] < m_len[i]) d = 1'b0;
        end
        return d;
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!m_pause[i] && m_pos[i] < m_len[i]) begin
                req_valid[i]                 = 1'b1;
                req_data[i*DATA_W +: DATA_W] = m_data[i][m_pos[i]];
                req_last[i]                  = m_last[i][m_pos[i]];
            end else begin
                req_valid[i]                 = 1'b0;
                req_data[i*DATA_W +: DATA_W] = 32'h0;
                req_last[i]                  = 1'b0;
            end
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit before posedge, check accepted beat.
    task automatic cycle();
        beat_t              e;
        logic [NUM_REQ-1:0] hs;
        drive();
        #4;
        s_gnt         = gnt;
        s_busy        = busy;
        s_err_timeout = err_timeout;
        s_err_burst   = err_burst;
        s_out_valid   = out_valid;
        s_out_data    = out_data;
        hs            = req_valid & req_ready;
        if (out_valid && out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: got id=%0d data=%h last=%b, required no beat", out_id, out_data, out_last);
            end else begin
                e = sb.pop_front();
                if ({out_id, out_data, out_last} !== {e.id, e.data, e.last}) begin
                    n_fail++;
                    $display("FAIL beat: got id=%0d data=%h last=%b, required id=%0d data=%h last=%b",
                             out_id, out_data, out_last, e.id, e.data, e.last);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs[i]) m_pos[i]++;
        end
        if (s_gnt == 4'b0000) begin
            gap++;
        end else begin
            if (prev_gnt == 4'b0000) begin
                gnt_log.push_back(s_gnt);
                gap_log.push_back(gap);
            end
            gap = 0;
        end
        prev_gnt = s_gnt;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            m_len[i]   = 0;
            m_pos[i]   = 0;
            m_pause[i] = 1'b0;
        end
        sb.delete();
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gnt_log.delete();
        gap_log.delete();
        prev_gnt = 4'b0000;
        s_gnt    = 4'b0000;
        gap      = 0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) m_pause[i] = 1'b0;
        load(0, 2, 2);
        load(1, 2, 2);
        drive();
        #1;
        n_tests++;
        if ({gnt, busy, out_id} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_gnt_busy_id: got gnt=%b busy=%b id=%0d, required 0", gnt, busy, out_id);
        end
        n_tests++;
        if ({out_valid, req_ready, err_timeout, err_burst} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b ready=%b errs=%b%b, required 0",
                     out_valid, req_ready, err_timeout, err_burst);
        end
        do_reset();
    endtask

    task automatic test_rr_order();
        logic [3:0] exp_g[5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        load(0, 4, 2);
        load(1, 2, 2);
        load(2, 2, 2);
        load(3, 2, 2);
        for (int r = 0; r < NUM_REQ; r++) begin
            exp_beat(r, 0, 1'b0);
            exp_beat(r, 1, 1'b1);
        end
        exp_beat(0, 2, 1'b0);
        exp_beat(0, 3, 1'b1);
        for (int c = 0; c < 60 && !drained(); c++) cycle();
        n_tests++;
        if (!drained()) begin
            n_fail++;
            $display("FAIL rr_drain: got %0d beats pending, required 0", sb.size());
        end
        n_tests++;
        if (gnt_log.size() != 5) begin
            n_fail++;
            $display("FAIL rr_grant_count: got %0d, required 5", gnt_log.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_tests++;
                if (gnt_log[k] !== exp_g[k]) begin
                    n_fail++;
                    $display("FAIL rr_grant_%0d: got %b, required %b", k, gnt_log[k], exp_g[k]);
                end
            end
            for (int k = 1; k < 5; k++) begin
                n_tests++;
                if (gap_log[k] != 1) begin
                    n_fail++;
                    $display("FAIL rr_gap_%0d: got %0d idle cycles, required 1", k, gap_log[k]);
                end
            end
        end
    endtask

    task automatic test_midburst_gap();
        int paused = 0;
        int bad    = 0;
        int errs   = 0;
        do_reset();
        load(1, 4, 4);
        load(2, 2, 2);
        for (int k = 0; k < 4; k++) exp_beat(1, k, k == 3);
        exp_beat(2, 0, 1'b0);
        exp_beat(2, 1, 1'b1);
        for (int c = 0; c < 60 && !drained(); c++) begin
            if (m_pos[1] == 2 && paused < 3) begin
                m_pause[1] = 1'b1;
                paused++;
            end else begin
                m_pause[1] = 1'b0;
            end
            cycle();
            if (m_pos[1] < 4 && s_busy && s_gnt !== 4'b0010) bad++;
            if (s_err_timeout || s_err_burst) errs++;
        end
        n_tests++;
        if (paused != 3 || bad != 0 || errs != 0) begin
            n_fail++;
            $display("FAIL gap_hold: got paused=%0d bad_gnt=%0d errs=%0d, required 3/0/0", paused, bad, errs);
        end
        n_tests++;
        if (gnt_log.size() != 2 || gnt_log[0] !== 4'b0010 || gnt_log[1] !== 4'b0100) begin
            n_fail++;
            $display("FAIL gap_order: got %0d grants first=%b, required 0010 then 0100",
                     gnt_log.size(), gnt_log.size() > 0 ? gnt_log[0] : 4'b0000);
        end
        n_tests++;
        if (!drained()) begin
            n_fail++;
            $display("FAIL gap_drain: got %0d beats pending, required 0", sb.size());
        end
    endtask

    task automatic test_timeout();
        int         k      = -1;
        int         t_at   = -1;
        int         pulses = 0;
        logic [3:0] g_at   = 4'b1111;
        do_reset();
        load(0, 4, 4);
        load(1, 2, 2);
        exp_beat(0, 0, 1'b0);
        exp_beat(1, 0, 1'b0);
        exp_beat(1, 1, 1'b1);
        exp_beat(0, 1, 1'b0);
        exp_beat(0, 2, 1'b0);
        exp_beat(0, 3, 1'b1);
        for (int c = 0; c < 200 && !(t_at >= 0 && drained()); c++) begin
            m_pause[0] = (m_pos[0] == 1) && (t_at < 0);
            if (m_pause[0] && k < 0) k = 0;
            cycle();
            if (s_err_timeout) begin
                pulses++;
                if (t_at < 0) begin
                    t_at = k;
                    g_at = s_gnt;
                end
            end
            if (k >= 0) k++;
        end
        n_tests++;
        if (t_at != TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_cycle: got %0d, required %0d", t_at, TIMEOUT);
        end
        n_tests++;
        if (pulses != 1 || g_at !== 4'b0000) begin
            n_fail++;
            $display("FAIL timeout_pulse: got pulses=%0d gnt=%b, required 1 and 0000", pulses, g_at);
        end
        n_tests++;
        if (gnt_log.size() != 3 || gnt_log[1] !== 4'b0010 || gnt_log[2] !== 4'b0001) begin
            n_fail++;
            $display("FAIL timeout_regrant: got %0d grants, required 0001,0010,0001", gnt_log.size());
        end
        n_tests++;
        if (!drained()) begin
            n_fail++;
            $display("FAIL timeout_drain: got %0d beats pending, required 0", sb.size());
        end
    endtask

    task automatic test_burst_trunc();
        bit         loaded0 = 1'b0;
        int         pulses  = 0;
        logic [3:0] g_at    = 4'b1111;
        do_reset();
        load(3, 20, 20);
        for (int k = 0; k < MAX_BURST; k++) exp_beat(3, k, k == MAX_BURST - 1);
        exp_beat(0, 0, 1'b0);
        exp_beat(0, 1, 1'b1);
        for (int k = MAX_BURST; k < 20; k++) exp_beat(3, k, k == 19);
        for (int c = 0; c < 100 && !(loaded0 && drained()); c++) begin
            if (!loaded0 && s_gnt == 4'b1000) begin
                load(0, 2, 2);
                loaded0 = 1'b1;
            end
            cycle();
            if (s_err_burst) begin
                pulses++;
                g_at = s_gnt;
            end
        end
        n_tests++;
        if (pulses != 1 || g_at !== 4'b0000) begin
            n_fail++;
            $display("FAIL trunc_err: got pulses=%0d gnt=%b, required 1 and 0000", pulses, g_at);
        end
        n_tests++;
        if (gnt_log.size() != 3 || gnt_log[0] !== 4'b1000 || gnt_log[1] !== 4'b0001 || gnt_log[2] !== 4'b1000) begin
            n_fail++;
            $display("FAIL trunc_order: got %0d grants, required 1000,0001,1000", gnt_log.size());
        end
        n_tests++;
        if (!drained()) begin
            n_fail++;
            $display("FAIL trunc_drain: got %0d beats pending, required 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        do_reset();
        load(0, 4, 4);
        for (int k = 0; k < 4; k++) exp_beat(0, k, k == 3);
        for (int c = 0; c < 10 && m_pos[0] < 1; c++) cycle();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (s_out_valid !== 1'b1 || s_out_data !== dat(0, 1) || s_err_timeout !== 1'b0 ||
                s_gnt !== 4'b0001 || m_pos[0] != 1) bad++;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && !drained(); c++) cycle();
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d bad stall cycles, required 0", bad);
        end
        n_tests++;
        if (!drained()) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d beats pending, required 0", sb.size());
        end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        load(0, 4, 4);
        for (int k = 0; k < 4; k++) exp_beat(0, k, k == 3);
        for (int c = 0; c < 10 && m_pos[0] < 2; c++) cycle();
        drive();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({gnt, busy, out_valid, req_ready} !== 10'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got gnt=%b busy=%b valid=%b ready=%b, required 0",
                     gnt, busy, out_valid, req_ready);
        end
        n_tests++;
        if (sb.size() != 2) begin
            n_fail++;
            $display("FAIL rst_mid_beats: got %0d beats left, required 2", sb.size());
        end
        sb.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            m_len[i] = 0;
            m_pos[i] = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        gnt_log.delete();
        gap_log.delete();
        prev_gnt = 4'b0000;
        load(2, 2, 2);
        load(0, 2, 2);
        exp_beat(0, 0, 1'b0);
        exp_beat(0, 1, 1'b1);
        exp_beat(2, 0, 1'b0);
        exp_beat(2, 1, 1'b1);
        for (int c = 0; c < 20 && !drained(); c++) cycle();
        n_tests++;
        if (gnt_log.size() < 1 || gnt_log[0] !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mid_first: got %0d grants first=%b, required 0001",
                     gnt_log.size(), gnt_log.size() > 0 ? gnt_log[0] : 4'b0000);
        end
        n_tests++;
        if (!drained()) begin
            n_fail++;
            $display("FAIL rst_mid_drain: got %0d beats pending, required 0", sb.size());
        end
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            m_len[i]   = 0;
            m_pos[i]   = 0;
            m_pause[i] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_rr_order();
        test_midburst_gap();
        test_timeout();
        test_burst_trunc();
        test_backpressure();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, required $finish before time limit");
        $fatal(1);
    end

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Shares one downstream valid/ready channel between NUM_REQ requesters that issue multi-beat bursts.
- Arbitration is round-robin at burst granularity. A grant is held until the winning requester's last beat is accepted.
- A watchdog releases a stalled owner, and a beat limit truncates over-long bursts.
- Sits between the requester-side bus masters and the shared resource port.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_W, 32, beat data width.
- MAX_BURST, 16, maximum beats per grant before forced termination (>=1).
- TIMEOUT, 64, consecutive owner-idle cycles in BUSY before forced release (>=2).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_W  per-requester beat data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  per-requester last-beat flag.
- req_ready  out  NUM_REQ  per-requester beat accept.
- out_valid  out  1  downstream beat valid.
- out_data  out  DATA_W  downstream beat data.
- out_last  out  1  downstream last-beat flag.
- out_id  out  $clog2(NUM_REQ)  index of current owner.
- out_ready  in  1  downstream accept.
- gnt  out  NUM_REQ  one-hot current owner; all zero when idle.
- busy  out  1  high while a grant is held.
- err_timeout  out  1  one-cycle pulse on watchdog release.
- err_burst  out  1  one-cycle pulse on MAX_BURST truncation.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. gnt=0, busy=0, err_*=0, out_valid=0, req_ready=0, out_id=0. Priority pointer ptr=NUM_REQ-1, so requester 0 wins first. beat_cnt=0, idle_cnt=0. Assertion mid-burst aborts immediately; no partial-burst recovery.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any req_valid is high, pick the first requester searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - Register the result: gnt, out_id and busy assert on the next edge, and state becomes BUSY.
  - Arbitration latency is 1 cycle. No beat is transferred in IDLE; req_ready=0.
- BUSY, owner g:
  - out_valid=req_valid[g], out_data=req_data[g], req_ready[g]=out_ready. All of these are combinational.
  - Other req_ready bits stay 0.
  - A beat is accepted when out_valid && out_ready.
- out_last = req_last[g] | (beat_cnt==MAX_BURST-1).
- Accepted beat with out_last=1:
  - Next edge: state=IDLE, gnt=0, busy=0, ptr=g, beat_cnt=0, idle_cnt=0.
  - If req_last[g]=0 at that beat, err_burst pulses for 1 cycle in that next cycle.
- Accepted beat with out_last=0: beat_cnt+1, idle_cnt cleared.
- Owner idle cycle (req_valid[g]=0 in BUSY): idle_cnt+1. A cycle with valid high but out_ready low does not count, and does not clear idle_cnt.
- Watchdog: when idle_cnt reaches TIMEOUT-1 while still idle:
  - Next edge: IDLE, gnt=0, ptr=g.
  - err_timeout pulses 1 cycle.
  - The remainder of the owner's burst is treated as a new burst on re-grant.
- Bursts are back-to-back with exactly one IDLE bubble between grants. A requester re-requesting immediately loses to any other active requester.
- A single-beat burst (req_last=1 on the first beat) is legal.
- MAX_BURST=1 truncates every beat that lacks req_last. err_burst fires only when req_last[g]=0.
- req_valid of non-owners may change freely; it is ignored until IDLE.
- Counter widths: beat_cnt $clog2(MAX_BURST+1) bits, idle_cnt $clog2(TIMEOUT+1) bits. Neither counter ever wraps.

Decomposition:
- Package rr_arb_pkg holds:
  - state enum (IDLE, BUSY);
  - a localparam width helper;
  - a function returning a one-hot mask rotated by ptr.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot pick, index, any_req.
  - Instantiated once in IDLE arbitration.

Test Plan:
- All four requesters valid with 2-beat bursts, out_ready=1 -> grants in order 0,1,2,3,0. gnt 0001,0010,0100,1000. One idle cycle between bursts.
- Requester 1 bursts; mid-burst req_valid[1] drops for 3 cycles, requester 2 valid -> gnt stays 0010, no err, and 2 is granted only after 1's last beat.
- Owner 0 stops for TIMEOUT=64 cycles -> err_timeout pulses at cycle 64 after the stall start, then gnt=0. The next grant goes to requester 1 if valid.
- Owner 3 sends 20 beats with req_last=0, MAX_BURST=16 -> out_last=1 on beat 16, err_burst pulses once, and ptr=3 so requester 0 wins next.
- out_ready held low 10 cycles during a burst, owner valid -> no timeout, data held stable, beat_cnt unchanged.
- rst_n asserted mid-burst -> gnt=0, busy=0 and out_valid=0 immediately. After release, requester 0 has first priority.
